// File: rtl/pc_seq_unit.sv
// pc_seq_unit: fetch program-counter sequencer with reset/boot sequencing.
// It selects the next fetch PC by fixed priority (trap, pending redirect,
// mret, branch, sequential), buffers redirects that arrive while stalled,
// and flags misaligned branch targets.
//
// Ports
//   clk_in               clock, rising edge
//   rst_in               synchronous reset, active-low
//   stall_in             hold PC; redirects are buffered
//   instr_16_in          current instruction is 16-bit (only used when C_EXT=1)
//   branch_taken_in      branch/jump request, target on branch_target_in
//   mret_in              return-from-trap request, target on epc_in
//   trap_taken_in        trap request, target on trap_vector_in
//   pc_out               registered fetch PC
//   i_addr_out           instruction address (= pc_out)
//   i_req_out            fetch request valid (RUN and not stalled)
//   pc_seq_out           sequential successor of pc_out
//   misaligned_instr_out one-cycle pulse per rejected branch target
//   misaligned_addr_out  last rejected branch target
module pc_seq_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter bit              C_EXT        = 1'b0
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            stall_in,
    input  logic            instr_16_in,
    input  logic            branch_taken_in,
    input  logic [XLEN-1:0] branch_target_in,
    input  logic            mret_in,
    input  logic [XLEN-1:0] epc_in,
    input  logic            trap_taken_in,
    input  logic [XLEN-1:0] trap_vector_in,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] i_addr_out,
    output logic            i_req_out,
    output logic [XLEN-1:0] pc_seq_out,
    output logic            misaligned_instr_out,
    output logic [XLEN-1:0] misaligned_addr_out
);

    localparam logic [XLEN-1:0] ALIGN_MASK = C_EXT ? XLEN'(1) : XLEN'(3);
    localparam logic [XLEN-1:0] STEP_2     = XLEN'(2);
    localparam logic [XLEN-1:0] STEP_4     = XLEN'(4);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_BOOT  = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e          state_q,      state_d;
    logic [XLEN-1:0] pc_q,         pc_d;
    logic            mis_q,        mis_d;
    logic [XLEN-1:0] mis_addr_q,   mis_addr_d;
    logic            pend_valid_q, pend_valid_d;
    logic            pend_trap_q,  pend_trap_d;
    logic [XLEN-1:0] pend_addr_q,  pend_addr_d;

    logic [XLEN-1:0] trap_tgt;
    logic [XLEN-1:0] epc_tgt;
    logic            br_misaligned;
    logic            br_ok;

    // Redirect targets and alignment check
    always_comb begin
        trap_tgt      = trap_vector_in & ~ALIGN_MASK;
        epc_tgt       = epc_in & ~ALIGN_MASK;
        br_misaligned = branch_taken_in && ((branch_target_in & ALIGN_MASK) != '0);
        br_ok         = branch_taken_in && !br_misaligned;
    end

    // Combinational views of the PC
    always_comb begin
        i_addr_out = pc_q;
        pc_seq_out = pc_q + ((C_EXT && instr_16_in) ? STEP_2 : STEP_4);
        i_req_out  = (state_q == ST_RUN) && !stall_in;
    end

    // Next-state, next-PC and stall buffering
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        mis_d        = 1'b0;
        mis_addr_d   = mis_addr_q;
        pend_valid_d = pend_valid_q;
        pend_trap_d  = pend_trap_q;
        pend_addr_d  = pend_addr_q;

        case (state_q)
            ST_RESET: state_d = ST_BOOT;
            ST_BOOT:  state_d = ST_RUN;
            ST_RUN: begin
                if (!stall_in) begin
                    if (trap_taken_in) begin
                        pc_d         = trap_tgt;
                        pend_valid_d = 1'b0;
                        pend_trap_d  = 1'b0;
                    end else if (pend_valid_q) begin
                        pc_d         = pend_addr_q;
                        pend_valid_d = 1'b0;
                        pend_trap_d  = 1'b0;
                    end else if (mret_in) begin
                        pc_d = epc_tgt;
                    end else if (br_ok) begin
                        pc_d = branch_target_in;
                    end else if (br_misaligned) begin
                        mis_d      = 1'b1;
                        mis_addr_d = branch_target_in;
                    end else begin
                        pc_d = pc_seq_out;
                    end
                end else begin
                    // A buffered trap cannot be displaced by a later mret/branch
                    if (trap_taken_in) begin
                        pend_addr_d  = trap_tgt;
                        pend_valid_d = 1'b1;
                        pend_trap_d  = 1'b1;
                    end else if (!pend_trap_q && mret_in) begin
                        pend_addr_d  = epc_tgt;
                        pend_valid_d = 1'b1;
                    end else if (!pend_trap_q && br_ok) begin
                        pend_addr_d  = branch_target_in;
                        pend_valid_d = 1'b1;
                    end
                    // Rejected branch is reported now rather than buffered
                    if (!trap_taken_in && !mret_in && br_misaligned) begin
                        mis_d      = 1'b1;
                        mis_addr_d = branch_target_in;
                    end
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q      <= ST_RESET;
            pc_q         <= RESET_VECTOR;
            mis_q        <= 1'b0;
            mis_addr_q   <= '0;
            pend_valid_q <= 1'b0;
            pend_trap_q  <= 1'b0;
            pend_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            mis_q        <= mis_d;
            mis_addr_q   <= mis_addr_d;
            pend_valid_q <= pend_valid_d;
            pend_trap_q  <= pend_trap_d;
            pend_addr_q  <= pend_addr_d;
        end
    end

    always_comb begin
        pc_out               = pc_q;
        misaligned_instr_out = mis_q;
        misaligned_addr_out  = mis_addr_q;
    end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Bench for pc_seq_unit: one instance with 4-byte alignment (C_EXT=0) and one
// with 2-byte alignment (C_EXT=1) share the same stimulus; each is compared
// against its own behavioural model every cycle.
module tb_pc_seq_unit;

    localparam logic [31:0] RV = 32'h100;

    logic        clk = 1'b0;
    logic        rst, stall, i16, br, mret, trap;
    logic [31:0] tgt, epc, tv;

    logic [31:0] pc0, ia0, seq0, ma0, pc1, ia1, seq1, ma1;
    logic        rq0, mi0, rq1, mi1;

    int n_vec = 0;
    int n_err = 0;

    // Model state per configuration (index = C_EXT)
    int          m_phase [2];   // 0 reset, 1 boot, 2 run
    logic [31:0] m_pc    [2];
    logic        m_mis   [2];
    logic [31:0] m_maddr [2];
    logic        m_pv    [2];
    logic        m_pt    [2];
    logic [31:0] m_pa    [2];

    always #5 clk = ~clk;

    pc_seq_unit #(.XLEN(32), .RESET_VECTOR(RV), .C_EXT(1'b0)) dut0 (
        .clk_in(clk), .rst_in(rst), .stall_in(stall), .instr_16_in(i16),
        .branch_taken_in(br), .branch_target_in(tgt), .mret_in(mret),
        .epc_in(epc), .trap_taken_in(trap), .trap_vector_in(tv),
        .pc_out(pc0), .i_addr_out(ia0), .i_req_out(rq0), .pc_seq_out(seq0),
        .misaligned_instr_out(mi0), .misaligned_addr_out(ma0)
    );

    pc_seq_unit #(.XLEN(32), .RESET_VECTOR(RV), .C_EXT(1'b1)) dut1 (
        .clk_in(clk), .rst_in(rst), .stall_in(stall), .instr_16_in(i16),
        .branch_taken_in(br), .branch_target_in(tgt), .mret_in(mret),
        .epc_in(epc), .trap_taken_in(trap), .trap_vector_in(tv),
        .pc_out(pc1), .i_addr_out(ia1), .i_req_out(rq1), .pc_seq_out(seq1),
        .misaligned_instr_out(mi1), .misaligned_addr_out(ma1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int c);
        m_phase[c] = 0;
        m_pc[c]    = RV;
        m_mis[c]   = 1'b0;
        m_maddr[c] = '0;
        m_pv[c]    = 1'b0;
        m_pt[c]    = 1'b0;
        m_pa[c]    = '0;
    endtask

    // Advance the model of configuration c by one clock edge
    task automatic model_step(input int c);
        int unsigned al;
        logic        bmis;
        al = (c == 1) ? 2 : 4;
        if (!rst) begin
            model_reset(c);
        end else if (m_phase[c] < 2) begin
            m_phase[c] = m_phase[c] + 1;
            m_mis[c]   = 1'b0;
        end else begin
            m_mis[c] = 1'b0;
            bmis     = br && ((tgt % al) != 0);
            if (!stall) begin
                if (trap) begin
                    m_pc[c] = tv - (tv % al); m_pv[c] = 1'b0; m_pt[c] = 1'b0;
                end else if (m_pv[c]) begin
                    m_pc[c] = m_pa[c]; m_pv[c] = 1'b0; m_pt[c] = 1'b0;
                end else if (mret) begin
                    m_pc[c] = epc - (epc % al);
                end else if (br && !bmis) begin
                    m_pc[c] = tgt;
                end else if (br) begin
                    m_mis[c] = 1'b1; m_maddr[c] = tgt;
                end else begin
                    m_pc[c] = m_pc[c] + ((c == 1 && i16) ? 32'd2 : 32'd4);
                end
            end else begin
                if (trap) begin
                    m_pa[c] = tv - (tv % al); m_pv[c] = 1'b1; m_pt[c] = 1'b1;
                end else if (!m_pt[c] && mret) begin
                    m_pa[c] = epc - (epc % al); m_pv[c] = 1'b1;
                end else if (!m_pt[c] && br && !bmis) begin
                    m_pa[c] = tgt; m_pv[c] = 1'b1;
                end
                if (!trap && !mret && bmis) begin
                    m_mis[c] = 1'b1; m_maddr[c] = tgt;
                end
            end
        end
    endtask

    // One clock: check combinational outputs, step models, check registered outputs
    task automatic cycle();
        logic [31:0] s0, s1;
        #1;
        s0 = m_pc[0] + 32'd4;
        s1 = m_pc[1] + (i16 ? 32'd2 : 32'd4);
        check_eq("c0_pc_seq", seq0, s0);
        check_eq("c1_pc_seq", seq1, s1);
        check_eq("c0_i_req", 32'(rq0), 32'(m_phase[0] == 2 && !stall));
        check_eq("c1_i_req", 32'(rq1), 32'(m_phase[1] == 2 && !stall));
        check_eq("c0_i_addr", ia0, m_pc[0]);
        check_eq("c1_i_addr", ia1, m_pc[1]);
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check_eq("c0_pc", pc0, m_pc[0]);
        check_eq("c1_pc", pc1, m_pc[1]);
        check_eq("c0_mis", 32'(mi0), 32'(m_mis[0]));
        check_eq("c1_mis", 32'(mi1), 32'(m_mis[1]));
        check_eq("c0_mis_addr", ma0, m_maddr[0]);
        check_eq("c1_mis_addr", ma1, m_maddr[1]);
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b1; stall = 1'b0; i16 = 1'b0; br = 1'b0; mret = 1'b0; trap = 1'b0;
        tgt = '0; epc = '0; tv = '0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        if ($urandom_range(0, 9) == 0) a = $urandom();
        else if ($urandom_range(0, 19) == 0) a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        else a = 32'($urandom_range(0, 1023)) << 2 | 32'($urandom_range(0, 3));
        return a;
    endfunction

    initial begin
        idle();
        rst = 1'b0;
        model_reset(0);
        model_reset(1);
        @(posedge clk);
        @(negedge clk);

        // Boot: 3 cycles in reset, then release
        for (int i = 0; i < 3; i++) cycle();
        idle();
        for (int i = 0; i < 4; i++) cycle();
        check_eq("boot_pc", pc0, 32'h108);

        // Priority: trap beats mret and branch
        idle(); trap = 1'b1; tv = 32'h200; cycle();
        check_eq("prio_setup_pc", pc0, 32'h200);
        idle(); trap = 1'b1; tv = 32'h80; mret = 1'b1; epc = 32'h500;
        br = 1'b1; tgt = 32'h400; cycle();
        check_eq("prio_pc_c0", pc0, 32'h80);
        check_eq("prio_pc_c1", pc1, 32'h80);
        idle(); cycle();
        check_eq("prio_dropped", pc0, 32'h84);

        // Stall case A: later mret wins over earlier branch
        idle(); stall = 1'b1; br = 1'b1; tgt = 32'h400; cycle();
        idle(); stall = 1'b1; mret = 1'b1; epc = 32'h500; cycle();
        idle(); stall = 1'b1; cycle();
        idle(); cycle();
        check_eq("stall_a_pc", pc0, 32'h500);

        // Stall case B: buffered trap is not displaced
        idle(); stall = 1'b1; trap = 1'b1; tv = 32'h80; br = 1'b1; tgt = 32'h400; cycle();
        idle(); stall = 1'b1; mret = 1'b1; epc = 32'h500; cycle();
        idle(); stall = 1'b1; cycle();
        idle(); cycle();
        check_eq("stall_b_pc", pc0, 32'h80);

        // Misaligned targets
        idle(); trap = 1'b1; tv = 32'h300; cycle();
        idle(); br = 1'b1; tgt = 32'h302; cycle();
        check_eq("mis_c0_hold", pc0, 32'h300);
        check_eq("mis_c0_pulse", 32'(mi0), 32'd1);
        check_eq("mis_c0_addr", ma0, 32'h302);
        check_eq("mis_c1_accept", pc1, 32'h302);
        idle(); cycle();
        check_eq("mis_c0_pulse_end", 32'(mi0), 32'd0);
        idle(); br = 1'b1; tgt = 32'h303; cycle();
        check_eq("mis_c1_reject", 32'(mi1), 32'd1);
        check_eq("mis_c1_addr", ma1, 32'h303);
        idle(); br = 1'b1; tgt = 32'h307; cycle();
        check_eq("mis_c1_b2b", 32'(mi1), 32'd1);

        // Compressed step and wrap
        idle(); trap = 1'b1; tv = 32'h10; cycle();
        idle(); i16 = 1'b1; cycle();
        check_eq("c16_c1", pc1, 32'h12);
        check_eq("c16_c0", pc0, 32'h14);
        idle(); trap = 1'b1; tv = 32'hFFFF_FFFC; cycle();
        idle(); cycle();
        check_eq("wrap_c0", pc0, 32'h0);
        check_eq("wrap_c1", pc1, 32'h0);

        // Reset mid-stall discards a pending branch
        idle(); stall = 1'b1; br = 1'b1; tgt = 32'h600; cycle();
        idle(); stall = 1'b1; rst = 1'b0; cycle();
        check_eq("rst_stall_pc", pc0, RV);
        idle(); cycle(); cycle();
        check_eq("rst_boot_pc", pc0, RV);
        idle(); cycle();
        check_eq("rst_boot_inc", pc0, RV + 32'd4);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            idle();
            rst   = ($urandom_range(0, 99) != 0);
            stall = ($urandom_range(0, 9) < 3);
            i16   = $urandom_range(0, 1) == 1;
            br    = ($urandom_range(0, 3) == 0);
            mret  = ($urandom_range(0, 9) == 0);
            trap  = ($urandom_range(0, 19) == 0);
            tgt   = rand_addr();
            epc   = rand_addr();
            tv    = rand_addr();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_seq_unit.md
# pc_seq_unit

Registered, parametrised program-counter sequencer for the STRV32I fetch stage. It owns the architectural fetch PC and the reset/boot sequence. It selects the next fetch address by fixed priority: trap, pending redirect, mret, branch, sequential. It buffers a redirect that arrives during a stall, supports 2-byte steps when compressed instructions are enabled, and flags misaligned branch targets so the trap logic can respond.

## Interface
- XLEN, 32: PC and address width.
- RESET_VECTOR, 0: first fetch address after reset.
- C_EXT, 0: 1 sets alignment to 2 bytes and enables 2-byte sequential steps. 0 sets alignment to 4 bytes.
- clk_in  in  1  single clock; all state updates on rising edge.
- rst_in  in  1  synchronous reset, active-low.
- stall_in  in  1  freeze PC (pipeline hold).
- instr_16_in  in  1  current instruction is 16-bit; ignored when C_EXT=0.
- branch_taken_in  in  1  branch/jump redirect request.
- branch_target_in  in  XLEN  branch/jump target.
- mret_in  in  1  return-from-trap request.
- epc_in  in  XLEN  mret target.
- trap_taken_in  in  1  trap redirect request.
- trap_vector_in  in  XLEN  trap handler address.
- pc_out  out  XLEN  registered current fetch PC.
- i_addr_out  out  XLEN  instruction memory address; equals pc_out.
- i_req_out  out  1  fetch request valid.
- pc_seq_out  out  XLEN  pc_out + 4, or pc_out + 2 when C_EXT=1 and instr_16_in=1.
- misaligned_instr_out  out  1  registered one-cycle pulse: a branch target was rejected.
- misaligned_addr_out  out  XLEN  captured rejected target; holds until the next rejection.

## Operation
- FSM states:
  - RESET: entered while rst_in=0. On release, go to BOOT.
  - BOOT: lasts exactly one cycle, then go to RUN.
  - RUN: normal operation.
- In RESET and BOOT, i_req_out=0 and pc_out holds RESET_VECTOR. All redirect inputs are ignored.
- In RUN, i_req_out=1 except when stall_in=1.
- Alignment mask: low 2 bits when C_EXT=0, bit 0 when C_EXT=1.
- A branch target is misaligned if any masked bit is set.
- trap_vector_in and epc_in have their masked bits forced to 0 on use. They never raise the misaligned flag.
- Next-PC priority in RUN with stall_in=0:
  1. trap_taken_in selects the masked trap_vector_in and clears any pending redirect.
  2. A pending redirect selects pend_addr and clears pending.
  3. mret_in selects the masked epc_in.
  4. branch_taken_in with an aligned target selects branch_target_in.
  5. branch_taken_in with a misaligned target holds pc_out, pulses misaligned_instr_out, and captures the target into misaligned_addr_out.
  6. Otherwise pc_seq_out.
- Stall buffering (RUN with stall_in=1):
  - pc_out holds.
  - A trap always writes pend_addr and sets pend_is_trap.
  - mret or an aligned branch writes pend_addr only if no trap is pending. The most recent such request wins.
  - A misaligned branch during a stall is flagged immediately and is not buffered.
- Arithmetic is modulo 2^XLEN: sequential increment from all-ones minus 3 (or minus 1 for a 2-byte step) wraps to 0 without any flag.
- rst_in=0 in any state, including mid-stall with a pending redirect, forces the reset values on the next edge.

## Timing
- Reset values:
  - pc_out = RESET_VECTOR
  - i_req_out = 0
  - misaligned_instr_out = 0
  - misaligned_addr_out = 0
  - pending cleared
  - state = RESET
- pc_seq_out and i_addr_out are combinational from pc_out. pc_seq_out is also combinational from instr_16_in.
- Redirect latency is one cycle: a request sampled at edge N appears on pc_out after edge N.
- Boot sequence: rst_in rises before edge 0. Edge 0 enters BOOT. Edge 1 enters RUN, and i_req_out=1 from then with i_addr_out=RESET_VECTOR. The first increment happens at edge 2.
- A pending redirect is applied at the first edge where stall_in=0, unless trap_taken_in is asserted at that same edge.
- misaligned_instr_out is high for exactly one cycle per rejected branch, including back-to-back rejections.

## Test plan
- Boot: rst_in=0 for 3 cycles, then 1, with RESET_VECTOR=32'h100. i_req_out is 0 for two edges, then 1 with i_addr_out=0x100, then 0x104 and 0x108 on following cycles.
- Priority: trap_taken_in, mret_in and branch_taken_in all asserted at pc=0x200 with trap_vector_in=0x80. Next pc_out=0x80, and mret and branch are dropped.
- Stall buffering:
  - Case A: stall for 3 cycles; branch to 0x400 in cycle 1, mret to 0x500 in cycle 2. After the stall releases, pc_out=0x500.
  - Case B: same, with a trap to 0x80 in cycle 1. pc_out=0x80.
- Misaligned, C_EXT=0: branch target 0x302 at pc=0x300. pc_out stays 0x300, misaligned_instr_out is a one-cycle pulse, misaligned_addr_out=0x302.
- Misaligned, C_EXT=1: target 0x302 is accepted; target 0x303 is rejected.
- Compressed and wrap, C_EXT=1, XLEN=32:
  - With instr_16_in=1 at pc=0x10, next pc is 0x12.
  - At pc=0xFFFFFFFC with instr_16_in=0, next pc is 0x00000000.
- Reset mid-stall: a pending branch to 0x600 is buffered, then rst_in=0 for one edge. pc_out=RESET_VECTOR, pending is discarded, and after boot fetch starts at RESET_VECTOR, not 0x600.
